// File: rtl/current_monitor_if.sv
// Sample/display bus of current_monitor: ADC sample strobe and data in,
// scaled current, display value and status flags out.
interface current_monitor_if;
  logic        adc_valid;
  logic [11:0] adc_data;
  logic        oc_clear;
  logic [15:0] current_live;
  logic [15:0] current_num;
  logic        sample_done;
  logic        overcurrent;

  modport master (
    output adc_valid, adc_data, oc_clear,
    input  current_live, current_num, sample_done, overcurrent
  );

  modport slave (
    input  adc_valid, adc_data, oc_clear,
    output current_live, current_num, sample_done, overcurrent
  );
endinterface

// File: rtl/current_monitor.sv
// Block-averages 12-bit current-sense samples, scales to mA with saturation,
// refreshes a slow display value and flags overcurrent with hysteresis.
// Optional feature macro: CURRENT_MON_OC_LATCH_EN (latching overcurrent, cleared by oc_clear).
module current_monitor #(
  parameter int AVG_LOG2    = 4,
  parameter int SCALE_MUL   = 1000,
  parameter int MAX_MA      = 999,
  parameter int OC_LIMIT_MA = 800,
  parameter int OC_HYST_MA  = 50,
  parameter int UPDATE_DIV  = 25_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  current_monitor_if.slave  bus
);

  localparam int ACC_W  = 12 + AVG_LOG2;
  localparam int PROD_W = 28;
  localparam int MA_W   = 16;
  localparam int DIV_W  = (UPDATE_DIV > 1) ? $clog2(UPDATE_DIV) : 1;

  localparam logic [MA_W-1:0]  MAX_MA_C  = MA_W'(MAX_MA);
  localparam logic [MA_W-1:0]  LIMIT_C   = MA_W'(OC_LIMIT_MA);
  localparam logic [MA_W-1:0]  RELEASE_C = MA_W'(OC_LIMIT_MA - OC_HYST_MA);
  localparam logic [DIV_W-1:0] DIV_TOP_C = DIV_W'(UPDATE_DIV - 1);

  function automatic logic [MA_W-1:0] sat_ma(input logic [PROD_W-1:0] prod);
    logic [MA_W-1:0] ma;
    ma = prod[PROD_W-1:12];
    return (ma > MAX_MA_C) ? MAX_MA_C : ma;
  endfunction

  logic [ACC_W-1:0]    acc_q;
  logic [AVG_LOG2-1:0] cnt_q;
  logic [ACC_W-1:0]    hold_p0_q;
  logic                vld_p0_q;
  logic [PROD_W-1:0]   prod_p1_q;
  logic                vld_p1_q;
  logic [MA_W-1:0]     live_q;
  logic                done_q;
  logic [MA_W-1:0]     num_q;
  logic [DIV_W-1:0]    div_q;
  logic                oc_q;

  logic [ACC_W-1:0]    sum_d;
  logic                blk_end_d;
  logic [11:0]         avg_d;
  logic [PROD_W-1:0]   prod_d;
  logic [MA_W-1:0]     live_d;
  logic                wrap_d;

  assign sum_d     = acc_q + ACC_W'(bus.adc_data);
  assign blk_end_d = bus.adc_valid && (cnt_q == '1);
  assign avg_d     = hold_p0_q[ACC_W-1:AVG_LOG2];
  assign prod_d    = PROD_W'(avg_d) * PROD_W'(SCALE_MUL);
  assign live_d    = sat_ma(prod_p1_q);
  assign wrap_d    = (div_q == DIV_TOP_C);

  // Stage p0: accumulate; the last sample of a block goes straight into the hold register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q     <= '0;
      cnt_q     <= '0;
      hold_p0_q <= '0;
      vld_p0_q  <= 1'b0;
    end else begin
      vld_p0_q <= blk_end_d;
      if (bus.adc_valid) begin
        cnt_q <= cnt_q + 1'b1;
        if (blk_end_d) begin
          acc_q     <= '0;
          hold_p0_q <= sum_d;
        end else begin
          acc_q <= sum_d;
        end
      end
    end
  end

  // Stage p1: average and multiply
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_p1_q <= '0;
      vld_p1_q  <= 1'b0;
    end else begin
      vld_p1_q <= vld_p0_q;
      if (vld_p0_q) prod_p1_q <= prod_d;
    end
  end

  // Stage p2: scale down, saturate, publish; display refresh prefers a same-cycle result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live_q <= '0;
      done_q <= 1'b0;
      num_q  <= '0;
      div_q  <= '0;
    end else begin
      done_q <= vld_p1_q;
      if (vld_p1_q) live_q <= live_d;
      div_q <= wrap_d ? '0 : div_q + 1'b1;
      if (wrap_d) num_q <= vld_p1_q ? live_d : live_q;
    end
  end

`ifdef CURRENT_MON_OC_LATCH_EN
  typedef enum logic [1:0] {ST_NORMAL = 2'd0, ST_OVER = 2'd1, ST_LATCHED = 2'd2} oc_state_e;
`else
  typedef enum logic [1:0] {ST_NORMAL = 2'd0, ST_OVER = 2'd1} oc_state_e;
  logic unused_oc_clear;
  assign unused_oc_clear = bus.oc_clear;
`endif

  oc_state_e state_q;

  // Overcurrent FSM, evaluated on each fresh live value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_NORMAL;
      oc_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_NORMAL: begin
          if (done_q && (live_q >= LIMIT_C)) begin
            state_q <= ST_OVER;
            oc_q    <= 1'b1;
          end
        end
        ST_OVER: begin
`ifdef CURRENT_MON_OC_LATCH_EN
          if (done_q) state_q <= ST_LATCHED;
`else
          if (done_q && (live_q < RELEASE_C)) begin
            state_q <= ST_NORMAL;
            oc_q    <= 1'b0;
          end
`endif
        end
`ifdef CURRENT_MON_OC_LATCH_EN
        ST_LATCHED: begin
          if (bus.oc_clear && (live_q < RELEASE_C)) begin
            state_q <= ST_NORMAL;
            oc_q    <= 1'b0;
          end
        end
`endif
        default: begin
          state_q <= ST_NORMAL;
          oc_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.current_live = live_q;
  assign bus.current_num  = num_q;
  assign bus.sample_done  = done_q;
  assign bus.overcurrent  = oc_q;

endmodule

// File: tb/tb_current_monitor.sv
// Directed bench for current_monitor: averaging, scaling, saturation,
// hysteresis, back-to-back samples, mid-block reset and display refresh.
module tb_current_monitor;

  logic clk = 1'b0;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc;

  current_monitor_if mon_if ();
  current_monitor_if sat_if ();

  current_monitor #(.UPDATE_DIV(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (mon_if)
  );

  current_monitor #(.UPDATE_DIV(16), .SCALE_MUL(2000)) dut_sat (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sat_if)
  );

  always #5 clk = ~clk;

  // Mirrors the display divider phase: cycles since reset release
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  initial begin
    #200000;
    $display("FAIL timeout: run did not complete");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [11:0] v);
    mon_if.adc_valid = 1'b1;
    mon_if.adc_data  = v;
    sat_if.adc_valid = 1'b1;
    sat_if.adc_data  = v;
    @(posedge clk);
    #1;
    mon_if.adc_valid = 1'b0;
    sat_if.adc_valid = 1'b0;
  endtask

  task automatic send_block(input logic [11:0] v);
    for (int i = 0; i < 16; i++) send(v);
  endtask

  initial begin
    rst_n            = 1'b0;
    mon_if.adc_valid = 1'b0;
    mon_if.adc_data  = '0;
    mon_if.oc_clear  = 1'b0;
    sat_if.adc_valid = 1'b0;
    sat_if.adc_data  = '0;
    sat_if.oc_clear  = 1'b0;
    step(3);
    chk("rst_live", mon_if.current_live, 16'd0);
    chk("rst_num",  mon_if.current_num,  16'd0);
    chk("rst_done", {15'd0, mon_if.sample_done}, 16'd0);
    chk("rst_oc",   {15'd0, mon_if.overcurrent}, 16'd0);
    rst_n = 1'b1;
    step(2);

    // Nominal: 2048 -> 500 mA, one-cycle pulse at t+2
    send_block(12'd2048);
    step(1);
    chk("nom_done_t1", {15'd0, mon_if.sample_done}, 16'd0);
    step(1);
    chk("nom_done_t2", {15'd0, mon_if.sample_done}, 16'd1);
    chk("nom_live",    mon_if.current_live, 16'd500);
    step(1);
    chk("nom_done_t3", {15'd0, mon_if.sample_done}, 16'd0);
    chk("nom_oc",      {15'd0, mon_if.overcurrent}, 16'd0);
    while (cyc % 16 != 0) step(1);
    chk("nom_num", mon_if.current_num, 16'd500);

    // Hysteresis: 820 asserts, 760 holds, 740 releases (or stays latched)
    send_block(12'd3359);
    step(2);
    chk("hys_live_820", mon_if.current_live, 16'd820);
    chk("hys_oc_t2",    {15'd0, mon_if.overcurrent}, 16'd0);
    step(1);
    chk("hys_oc_820",   {15'd0, mon_if.overcurrent}, 16'd1);
    send_block(12'd3113);
    step(2);
    chk("hys_live_760", mon_if.current_live, 16'd760);
    step(1);
    chk("hys_oc_760",   {15'd0, mon_if.overcurrent}, 16'd1);
    send_block(12'd3032);
    step(2);
    chk("hys_live_740", mon_if.current_live, 16'd740);
    step(1);
`ifdef CURRENT_MON_OC_LATCH_EN
    chk("hys_oc_740",   {15'd0, mon_if.overcurrent}, 16'd1);
`else
    chk("hys_oc_740",   {15'd0, mon_if.overcurrent}, 16'd0);
`endif
    mon_if.oc_clear = 1'b1;
    step(1);
    mon_if.oc_clear = 1'b0;
    chk("hys_oc_clr",   {15'd0, mon_if.overcurrent}, 16'd0);

    // Saturation: full scale at 2x multiplier clamps to 999
    send_block(12'd4095);
    step(2);
    chk("sat_live_x2", sat_if.current_live, 16'd999);
    chk("sat_live_x1", mon_if.current_live, 16'd999);
    step(1);
    chk("sat_oc",      {15'd0, mon_if.overcurrent}, 16'd1);

    // Back-to-back ramp 0..31: two blocks, no sample lost at the boundary
    for (int i = 0; i < 32; i++) begin
      send(12'(i));
      if (i == 16) chk("ramp_done_pre", {15'd0, mon_if.sample_done}, 16'd0);
      if (i == 17) begin
        chk("ramp_live1", mon_if.current_live, 16'd1);
        chk("ramp_done1", {15'd0, mon_if.sample_done}, 16'd1);
      end
      if (i == 18) begin
        chk("ramp_done1_end", {15'd0, mon_if.sample_done}, 16'd0);
`ifdef CURRENT_MON_OC_LATCH_EN
        chk("ramp_oc", {15'd0, mon_if.overcurrent}, 16'd1);
`else
        chk("ramp_oc", {15'd0, mon_if.overcurrent}, 16'd0);
`endif
      end
    end
    step(2);
    chk("ramp_live2", mon_if.current_live, 16'd5);
    chk("ramp_done2", {15'd0, mon_if.sample_done}, 16'd1);

    // Reset mid-block: the partial 4095 sum must not leak into the next block
    for (int i = 0; i < 10; i++) send(12'd4095);
    rst_n = 1'b0;
    #1;
    chk("mrst_live", mon_if.current_live, 16'd0);
    chk("mrst_num",  mon_if.current_num,  16'd0);
    chk("mrst_done", {15'd0, mon_if.sample_done}, 16'd0);
    chk("mrst_oc",   {15'd0, mon_if.overcurrent}, 16'd0);
    chk("mrst_sat",  sat_if.current_live, 16'd0);
    step(2);
    rst_n = 1'b1;
    send_block(12'd1024);
    step(2);
    chk("mrst_live_250", mon_if.current_live, 16'd250);
    chk("mrst_done_250", {15'd0, mon_if.sample_done}, 16'd1);
    step(1);
    while (cyc % 16 != 0) step(1);
    chk("mrst_num_250", mon_if.current_num, 16'd250);

    // Collision: the S2 write lands exactly on a divider wrap
    while (cyc % 16 != 14) step(1);
    send_block(12'd3032);
    step(2);
    chk("col_live", mon_if.current_live, 16'd740);
    chk("col_done", {15'd0, mon_if.sample_done}, 16'd1);
    chk("col_num",  mon_if.current_num,  16'd740);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
